// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, rest tone, pair width.
package note_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap
    } state_e;

    localparam logic [7:0]  REST_TONE = 8'h00;
    localparam int unsigned PAIR_W    = 16;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of {tone, duration} pairs with simultaneous push/pop and flush.
module note_fifo
    import note_seq_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [PAIR_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [PAIR_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PAIR_W-1:0] mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full queue is accepted when a pop frees a slot in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/note_sequencer.sv
// Assembles UART tone/duration byte pairs into a queue and plays them on a beeper,
// with ms-tick timing, pause, flush and an optional inter-note gap.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned UNIT_MS    = 10,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned GAP_MS     = 5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    input  logic       pause,
    input  logic       flush,
    output logic       tone_en,
    output logic [7:0] music_tone,
    output logic       playing,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned TickDiv = CLK_FREQ / 1000;
    localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned DurW    = $clog2(255 * UNIT_MS + 1);
    localparam int unsigned GapW    = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;

    state_e              state_q, state_d;
    logic                phase_q;
    logic [7:0]          tone_byte_q;
    logic                pend_q;
    logic [PAIR_W-1:0]   pend_data_q;
    logic                overflow_q;
    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [DurW-1:0]     dur_cnt_q, dur_cnt_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [7:0]          music_tone_q, music_tone_d;
    logic                tone_en_q, tone_en_d;
    logic                tick;
    logic                fifo_pop, fifo_push, fifo_empty, fifo_full_w;
    logic [PAIR_W-1:0]   fifo_head;

    assign fifo_push = pend_q & (~fifo_full_w | fifo_pop);

    // Byte pairing: the completed pair is staged one cycle before it reaches the queue.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_q     <= 1'b0;
            tone_byte_q <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            overflow_q  <= 1'b0;
        end else if (flush) begin
            phase_q    <= 1'b0;
            pend_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= 1'b0;
            overflow_q <= pend_q & ~fifo_push;
            if (uart_done) begin
                if (!phase_q) begin
                    tone_byte_q <= uart_data;
                    phase_q     <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    if (uart_data != 8'd0) begin
                        pend_q      <= 1'b1;
                        pend_data_q <= {tone_byte_q, uart_data};
                    end
                end
            end
        end
    end

    note_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .flush_i (flush),
        .push_i  (fifo_push),
        .wdata_i (pend_data_q),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty)
    );

    assign tick = ~pause & (tick_cnt_q == TickW'(TickDiv - 1));

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (state_q == StLoad) tick_cnt_d = '0;
        else if (tick)         tick_cnt_d = '0;
        else if (!pause)       tick_cnt_d = tick_cnt_q + TickW'(1);
    end

    always_comb begin
        state_d      = state_q;
        music_tone_d = music_tone_q;
        dur_cnt_d    = dur_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        fifo_pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !pause) state_d = StLoad;
            end
            StLoad: begin
                fifo_pop     = 1'b1;
                music_tone_d = fifo_head[15:8];
                dur_cnt_d    = DurW'(fifo_head[7:0]) * DurW'(UNIT_MS);
                state_d      = StPlay;
            end
            StPlay: begin
                if (tick) begin
                    dur_cnt_d = dur_cnt_q - DurW'(1);
                    if (dur_cnt_q == DurW'(1)) begin
                        if (GAP_MS != 0) begin
                            state_d   = StGap;
                            gap_cnt_d = GapW'(GAP_MS);
                        end else begin
                            state_d = fifo_empty ? StIdle : StLoad;
                        end
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                    if (gap_cnt_q == GapW'(1)) state_d = fifo_empty ? StIdle : StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d      = StIdle;
            music_tone_d = REST_TONE;
            dur_cnt_d    = '0;
            gap_cnt_d    = '0;
            fifo_pop     = 1'b0;
        end
        tone_en_d = (state_d == StPlay) & (music_tone_d != REST_TONE) & ~pause;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            dur_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            music_tone_q <= REST_TONE;
            tone_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            dur_cnt_q    <= dur_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            music_tone_q <= music_tone_d;
            tone_en_q    <= tone_en_d;
        end
    end

    assign tone_en    = tone_en_q;
    assign music_tone = music_tone_q;
    assign playing    = (state_q != StIdle);
    assign fifo_full  = fifo_full_w;
    assign overflow   = overflow_q;

endmodule
